// File: rtl/bin_to_bcd_8digit_if.sv
// rtl/bin_to_bcd_8digit_if.sv - request/result bundle between a value source and the BCD converter.
interface bin_to_bcd_8digit_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
);
  logic                  start;
  logic [IN_WIDTH-1:0]   bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd
  );
endinterface

// File: rtl/bin_to_bcd_8digit.sv
// rtl/bin_to_bcd_8digit.sv - sequential double-dabble binary to 8-digit packed BCD converter.
module bin_to_bcd_8digit #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bin_to_bcd_8digit_if.slave bus
);

  localparam int          CW      = $clog2(IN_WIDTH + 1);
  localparam int          BW      = 4 * DIGITS;
  localparam logic [32:0] MAX_BCD = 33'd99_999_999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   shift_q;
  logic [BW-1:0]         scratch_q;
  logic [BW-1:0]         adj;
  logic [BW-1:0]         scratch_nxt;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_pend_q;
  logic                  ovf_in;
  logic                  accept;
  logic                  last_shift;
  logic [BW-1:0]         bcd_q;
  logic                  overflow_q;

  // Zero-extending both sides keeps narrow IN_WIDTH builds at a constant 0.
  assign ovf_in = 33'(bus.bin_in) > MAX_BCD;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_nxt = {adj[BW-2:0], shift_q[IN_WIDTH-1]};
  end

  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The result register is written from the final shift so it is valid on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      shift_q    <= bus.bin_in;
      scratch_q  <= '0;
      cnt_q      <= CW'(IN_WIDTH);
      ovf_pend_q <= ovf_in;
    end else if (state_q == SHIFT) begin
      shift_q   <= shift_q << 1;
      scratch_q <= scratch_nxt;
      cnt_q     <= cnt_q - CW'(1);
      if (last_shift) begin
        bcd_q      <= ovf_pend_q ? '1 : scratch_nxt;
        overflow_q <= ovf_pend_q;
      end
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

endmodule
